// File: rtl/spi_sram_responder_if.sv
// spi_sram_responder_if
//  Groups the SPI pins, the backdoor load port and the status outputs of
//  spi_sram_responder into one bundle.
//  Ports (all carried as interface signals):
//   sclk, cs_n, mosi   : SPI from initiator (idle low clock, active-low select)
//   miso               : SPI data back to initiator
//   load_en/addr/data  : backdoor byte write into the memory array
//   busy, cmd_err      : frame-active flag and bad-command pulse
//  Modports: master = initiator/bench side, slave = responder side.
interface spi_sram_responder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [7:0]            load_data;
  logic                  busy;
  logic                  cmd_err;

  modport master (
    output sclk, cs_n, mosi, load_en, load_addr, load_data,
    input  miso, busy, cmd_err
  );

  modport slave (
    input  sclk, cs_n, mosi, load_en, load_addr, load_data,
    output miso, busy, cmd_err
  );
endinterface

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//  SPI mode-0 target behaving like a 23x-series serial SRAM: READ 0x03 and
//  WRITE 0x02 with a 16-bit address and streaming 8-bit data. The SPI pins are
//  oversampled in the clk domain (clk >= 8x sclk). The byte array can also be
//  written through a backdoor port, e.g. to preload a ROM image.
//  Ports:
//   clk      : oversampling clock
//   rst      : asynchronous active-high reset
//   mem_bus  : spi_sram_responder_if.slave (SPI pins, backdoor port, busy, cmd_err)
//  Parameters:
//   ADDR_WIDTH : implemented address bits; upper SPI address bits are ignored
//   INIT_ZERO  : 1 clears the array on rst, 0 leaves it untouched
module spi_sram_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter bit INIT_ZERO  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  spi_sram_responder_if.slave mem_bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, DROP} state_t;

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_t                state_q;
  logic [3:0]            bit_cnt_q;
  logic                  is_rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [6:0]            in_shift_q;
  logic [7:0]            out_shift_q;
  logic                  fetch_q;
  logic                  miso_q;
  logic                  busy_q;
  logic                  cmd_err_q;

  logic [7:0]            mem [DEPTH];

  logic                  sclk_rise, sclk_fall, cs_fall;
  logic [7:0]            rx_byte;
  logic [7:0]            rd_word;
  logic                  spi_we;
  logic [ADDR_WIDTH-1:0] addr_shift_d;

  // The chip-select synchroniser resets to the "selected" level so that a
  // cs_n held low across reset is never mistaken for a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= mem_bus.sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= mem_bus.cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= mem_bus.mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise    = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall    = ~sclk_sync_q & sclk_prev_q;
  assign cs_fall      = cs_prev_q & ~cs_sync_q;
  assign rx_byte      = {in_shift_q, mosi_sync_q};
  assign addr_shift_d = {addr_q[ADDR_WIDTH-2:0], mosi_sync_q};

  // A fetch still pending when a fall arrives is served straight from the array.
  assign rd_word = fetch_q ? mem[addr_q] : out_shift_q;
  assign spi_we  = (state_q == WDATA) && !cs_sync_q && sclk_rise && (bit_cnt_q == 4'd0);

  // Protocol FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      in_shift_q  <= '0;
      out_shift_q <= '0;
      fetch_q     <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      if (cs_sync_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        miso_q  <= 1'b0;
        fetch_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q   <= CMD;
              bit_cnt_q <= 4'd7;
              busy_q    <= 1'b1;
              miso_q    <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              in_shift_q <= rx_byte[6:0];
              if (bit_cnt_q == 4'd0) begin
                bit_cnt_q <= 4'd15;
                if (rx_byte == 8'h03) begin
                  is_rd_q <= 1'b1;
                  state_q <= ADDR;
                end else if (rx_byte == 8'h02) begin
                  is_rd_q <= 1'b0;
                  state_q <= ADDR;
                end else begin
                  cmd_err_q <= 1'b1;
                  state_q   <= DROP;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr_q <= addr_shift_d;
              if (bit_cnt_q == 4'd0) begin
                bit_cnt_q <= 4'd7;
                if (is_rd_q) begin
                  state_q <= RDATA;
                  fetch_q <= 1'b1;
                end else begin
                  state_q <= WDATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              miso_q <= rd_word[7];
              if (bit_cnt_q == 4'd0) begin
                addr_q    <= addr_q + 1'b1;
                fetch_q   <= 1'b1;
                bit_cnt_q <= 4'd7;
              end else begin
                out_shift_q <= {rd_word[6:0], 1'b0};
                fetch_q     <= 1'b0;
                bit_cnt_q   <= bit_cnt_q - 1'b1;
              end
            end else if (fetch_q) begin
              out_shift_q <= mem[addr_q];
              fetch_q     <= 1'b0;
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              in_shift_q <= rx_byte[6:0];
              if (bit_cnt_q == 4'd0) begin
                addr_q    <= addr_q + 1'b1;
                bit_cnt_q <= 4'd7;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end
          DROP: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Array writes: the SPI write is issued last so it wins an address collision
  // with the backdoor port in the same clk.
  generate
    if (INIT_ZERO) begin : g_mem_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
          if (mem_bus.load_en) mem[mem_bus.load_addr] <= mem_bus.load_data;
          if (spi_we) mem[addr_q] <= rx_byte;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (mem_bus.load_en) mem[mem_bus.load_addr] <= mem_bus.load_data;
        if (spi_we) mem[addr_q] <= rx_byte;
      end
    end
  endgenerate

  assign mem_bus.miso    = miso_q;
  assign mem_bus.busy    = busy_q;
  assign mem_bus.cmd_err = cmd_err_q;
endmodule

// File: tb/tb_spi_sram_responder.sv
// tb_spi_sram_responder
//  Drives spi_sram_responder as an SPI initiator (sclk = clk/8) and through the
//  backdoor port. Every byte clocked out on miso goes to a scoreboard whose
//  expected bytes come from a plain byte-array model of the memory.
module tb_spi_sram_responder;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_sram_responder_if #(.ADDR_WIDTH(AW)) mem_bus ();

  spi_sram_responder #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (mem_bus)
  );

  int         total = 0;
  int         bad = 0;
  int         errCount = 0;
  int         errExpected = 0;
  logic [7:0] refMem [DEPTH];
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] wbuf[$];

  // One comparison: counts it and reports a miss.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Counts cmd_err pulses, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_bus.cmd_err === 1'b1) errCount++;
    end
  end

  // Scoreboard monitor: pairs every received miso byte with its expectation.
  initial begin : scoreboard
    logic [7:0] got;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      while (rxQ.size() != 0) begin
        got = rxQ.pop_front();
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL miso_byte actual=%02h required=none", got);
        end else begin
          want = expQ.pop_front();
          checkOutput("miso_byte", 32'(got), 32'(want));
        end
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic loadByte(input logic [AW-1:0] addr, input logic [7:0] data);
    @(negedge clk);
    mem_bus.load_en   = 1'b1;
    mem_bus.load_addr = addr;
    mem_bus.load_data = data;
    @(negedge clk);
    mem_bus.load_en   = 1'b0;
    refMem[addr]      = data;
  endtask

  // Mode-0 bit clocking: mosi changes while sclk is low, miso captured at the rise.
  task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mem_bus.mosi = tx[i];
      #HALF;
      mem_bus.sclk = 1'b1;
      rx[i] = mem_bus.miso;
      #HALF;
      mem_bus.sclk = 1'b0;
    end
  endtask

  task automatic spiByte(input logic [7:0] tx, input logic [7:0] want);
    logic [7:0] rx;
    expQ.push_back(want);
    spiBits(tx, 8, rx);
    rxQ.push_back(rx);
  endtask

  task automatic csLow();
    @(negedge clk);
    #2;
    mem_bus.cs_n = 1'b0;
    #HALF;
  endtask

  task automatic csHigh();
    #HALF;
    mem_bus.cs_n = 1'b1;
    #(2 * HALF);
  endtask

  // One complete frame; the model supplies read data and absorbs write data.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] addr, input int n);
    logic [AW-1:0] a;
    csLow();
    checkOutput("busy_in_frame", 32'(mem_bus.busy), 32'd1);
    spiByte(cmd, 8'h00);
    spiByte(addr[15:8], 8'h00);
    spiByte(addr[7:0], 8'h00);
    a = addr[AW-1:0];
    for (int i = 0; i < n; i++) begin
      if (cmd == 8'h03) begin
        spiByte(8'($urandom), refMem[a]);
      end else if (cmd == 8'h02) begin
        spiByte(wbuf[i], 8'h00);
        refMem[a] = wbuf[i];
      end else begin
        spiByte(8'($urandom), 8'h00);
      end
      a = a + 1'b1;
    end
    if (cmd != 8'h02 && cmd != 8'h03) errExpected++;
    csHigh();
    checkOutput("busy_after_frame", 32'(mem_bus.busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [15:0] ra;
    int          n;

    mem_bus.sclk      = 1'b0;
    mem_bus.cs_n      = 1'b1;
    mem_bus.mosi      = 1'b0;
    mem_bus.load_en   = 1'b0;
    mem_bus.load_addr = '0;
    mem_bus.load_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_miso", 32'(mem_bus.miso), 32'd0);
    checkOutput("reset_busy", 32'(mem_bus.busy), 32'd0);
    checkOutput("reset_cmd_err", 32'(mem_bus.cmd_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] preloading random image");
    for (int i = 0; i < DEPTH; i++) loadByte(AW'(i), 8'($urandom));

    $display("[TB] single read of a backdoor image");
    for (int i = 0; i < 16; i++) loadByte(AW'(i), 8'(8'hA0 + i));
    applyStimulus(8'h03, 16'h0005, 1);

    $display("[TB] streamed write then read back");
    wbuf.delete();
    wbuf.push_back(8'h3C);
    wbuf.push_back(8'hC3);
    applyStimulus(8'h02, 16'h0010, 2);
    applyStimulus(8'h03, 16'h0010, 2);

    $display("[TB] address wrap");
    loadByte(AW'(8'hFF), 8'h11);
    loadByte(AW'(8'h00), 8'h22);
    applyStimulus(8'h03, 16'h00FF, 2);

    $display("[TB] unknown command");
    applyStimulus(8'h9F, 16'h1234, 2);
    repeat (4) @(negedge clk);
    checkOutput("cmd_err_pulses", 32'(errCount), 32'(errExpected));
    applyStimulus(8'h03, 16'h0005, 1);

    $display("[TB] partial write byte is discarded");
    csLow();
    spiByte(8'h02, 8'h00);
    spiByte(8'h00, 8'h00);
    spiByte(8'h20, 8'h00);
    spiBits(8'($urandom), 5, rx);
    csHigh();
    applyStimulus(8'h03, 16'h0020, 1);

    $display("[TB] reset during read address phase");
    csLow();
    spiByte(8'h03, 8'h00);
    spiBits(8'h00, 4, rx);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_miso", 32'(mem_bus.miso), 32'd0);
    checkOutput("rst_mid_busy", 32'(mem_bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    spiBits(8'h00, 4, rx);
    spiByte(8'h03, 8'h00);
    spiByte(8'h00, 8'h00);
    spiByte(8'h05, 8'h00);
    spiByte(8'($urandom), 8'h00);
    checkOutput("no_frame_without_fall", 32'(mem_bus.busy), 32'd0);
    csHigh();
    applyStimulus(8'h03, 16'h0005, 1);

    $display("[TB] alternating random write/read frames");
    for (int k = 0; k < 16; k++) begin
      ra = 16'($urandom);
      n  = $urandom_range(1, 3);
      wbuf.delete();
      for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
      applyStimulus(8'h02, ra, n);
      applyStimulus(8'h03, ra, n + 1);
    end

    repeat (8) @(negedge clk);
    checkOutput("cmd_err_total", 32'(errCount), 32'(errExpected));
    checkOutput("scoreboard_left", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
